// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M iterative multiply/divide unit:
//   - M-extension funct3 / funct7 encodings
//   - FSM state encoding
//   - helpers that say which operands are treated as signed for a funct3
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 6;

   // M-extension R-type marker
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // funct3 encodings
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // rs1 is signed for MULH, MULHSU, DIV, REM (MUL low word is sign-agnostic)
   function automatic logic op1_is_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
         default:                            s = 1'b0;
      endcase
      return s;
   endfunction

   // rs2 is signed for MULH, DIV, REM
   function automatic logic op2_is_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MULH, F3_DIV, F3_REM: s = 1'b1;
         default:                 s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// -----------------------------------------------------------------------------
// muldiv_negate
// Combinational conditional two's-complement negator.
// Ports:
//   neg  : 1 = output -val, 0 = output val
//   val  : WIDTH-bit input value
//   out  : WIDTH-bit result
// -----------------------------------------------------------------------------
module muldiv_negate #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] val,
   output logic [WIDTH-1:0] out
);

   // conditional negate
   always_comb begin
      if (neg) begin
         out = ~val + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         out = val;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// sharing one XLEN+1-bit adder. Normal ops take 32 CALC cycles + FIX + DONE;
// divide-by-zero and signed overflow are resolved on the start cycle.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   start  : one-cycle request, sampled only in IDLE
//   flush  : abort the operation in progress (CALC/FIX), blocks start in IDLE
//   funct3 : M-extension operation select
//   op1    : rs1 (multiplicand / dividend)
//   op2    : rs2 (multiplier / divisor)
//   busy   : high while in CALC/FIX
//   done   : one-cycle pulse, result valid
//   result : registered result, held until overwritten by a later operation
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // State and datapath registers.
   // hi_q : multiply accumulator high half / divide remainder
   // lo_q : multiplier (shifted out as product low half) / dividend->quotient
   // b_q  : multiplicand / divisor magnitude
   state_e            state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              neg_q, neg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Start-cycle decode
   logic              a_neg_s, b_neg_s;
   logic              is_div_s, div_zero_s, ovf_s;
   logic [XLEN-1:0]   a_abs_s, b_abs_s, special_res_s;

   // Shared adder
   logic              is_div_q_s;
   logic [XLEN:0]     rem_sh_s, add_a_s, add_b_s;
   logic [XLEN+1:0]   sum_s;
   logic [XLEN-1:0]   mul_hi_s;
   logic              mul_c_s;

   // 64-bit negator: op2 magnitude in IDLE, final sign fix in FIX
   logic              n64_neg_s;
   logic [2*XLEN-1:0] n64_in_s, n64_out_s, fix_val_s;

   assign is_div_s   = funct3[2];
   assign a_neg_s    = op1_is_signed(funct3) & op1[XLEN-1];
   assign b_neg_s    = op2_is_signed(funct3) & op2[XLEN-1];
   assign div_zero_s = is_div_s & (op2 == ZERO);
   assign ovf_s      = is_div_s & ~funct3[0] & (op1 == MIN_VAL) & (op2 == ONES);
   assign b_abs_s    = n64_out_s[XLEN-1:0];
   assign is_div_q_s = f3_q[2];

   muldiv_negate #(.WIDTH(XLEN)) u_neg_op1 (
      .neg (a_neg_s),
      .val (op1),
      .out (a_abs_s)
   );

   muldiv_negate #(.WIDTH(2*XLEN)) u_neg_wide (
      .neg (n64_neg_s),
      .val (n64_in_s),
      .out (n64_out_s)
   );

   // special-case result: divide by zero or signed overflow
   always_comb begin
      if (div_zero_s) begin
         special_res_s = funct3[1] ? op1 : ONES;
      end else begin
         special_res_s = funct3[1] ? ZERO : MIN_VAL;
      end
   end

   // select what the wide negator works on (IDLE: op2, otherwise FIX value)
   always_comb begin
      if (f3_q[2] == 1'b0) begin
         fix_val_s = {hi_q, lo_q};
      end else if (f3_q[1]) begin
         fix_val_s = {ZERO, hi_q};
      end else begin
         fix_val_s = {ZERO, lo_q};
      end
      if (state_q == ST_IDLE) begin
         n64_in_s  = {ZERO, op2};
         n64_neg_s = b_neg_s;
      end else begin
         n64_in_s  = fix_val_s;
         n64_neg_s = neg_q;
      end
   end

   // shared adder: add multiplicand (multiply) or subtract divisor (divide)
   always_comb begin
      rem_sh_s = {hi_q, lo_q[XLEN-1]};
      if (is_div_q_s) begin
         add_a_s = rem_sh_s;
         add_b_s = ~{1'b0, b_q};
      end else begin
         add_a_s = {1'b0, hi_q};
         add_b_s = {1'b0, b_q};
      end
      // bit XLEN+1 is the carry: for divide it means "no borrow" (rem >= divisor)
      sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(XLEN+1){1'b0}}, is_div_q_s};
      if (lo_q[0]) begin
         mul_c_s  = sum_s[XLEN];
         mul_hi_s = sum_s[XLEN-1:0];
      end else begin
         mul_c_s  = 1'b0;
         mul_hi_s = hi_q;
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               f3_d  = funct3;
               cnt_d = {CNT_W{1'b0}};
               hi_d  = ZERO;
               lo_d  = is_div_s ? a_abs_s : b_abs_s;
               b_d   = is_div_s ? b_abs_s : a_abs_s;
               // remainder follows op1's sign; quotient/product follow sign xor
               neg_d = (is_div_s && funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
               if (div_zero_s || ovf_s) begin
                  result_d = special_res_s;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_CALC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (is_div_q_s) begin
                  if (sum_s[XLEN+1]) begin
                     hi_d = sum_s[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b1};
                  end else begin
                     hi_d = rem_sh_s[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  hi_d = {mul_c_s, mul_hi_s[XLEN-1:1]};
                  lo_d = {mul_hi_s[0], lo_q[XLEN-1:1]};
               end
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_FIX: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (f3_q == F3_MUL) begin
                  result_d = n64_out_s[XLEN-1:0];
               end else if (f3_q[2] == 1'b0) begin
                  result_d = n64_out_s[2*XLEN-1:XLEN];
               end else begin
                  result_d = n64_out_s[XLEN-1:0];
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
      done_d = (state_d == ST_DONE);
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         f3_q     <= 3'b000;
         hi_q     <= ZERO;
         lo_q     <= ZERO;
         b_q      <= ZERO;
         neg_q    <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         result_q <= ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Table-driven directed vectors, hand-written flush/reset/back-to-back
// sequences, and random operations checked against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .op1    (op1),
      .op2    (op2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arithmetic reference: RV32M rules in plain 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic [31:0]     r;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r   = 32'h0;
      case (f3)
         3'b000: begin p = 64'(ua * ub);          r = p[31:0];  end
         3'b001: begin p = 64'(sa * sb);          r = p[63:32]; end
         3'b010: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
         3'b011: begin p = 64'(ua * ub);          r = p[63:32]; end
         3'b100: begin
            if (b == 32'h0)  r = 32'hFFFF_FFFF;
            else if (ovf)    r = 32'h8000_0000;
            else begin p = 64'(sa / sb); r = p[31:0]; end
         end
         3'b101: begin
            if (b == 32'h0) r = 32'hFFFF_FFFF;
            else begin p = 64'(ua / ub); r = p[31:0]; end
         end
         3'b110: begin
            if (b == 32'h0)  r = a;
            else if (ovf)    r = 32'h0;
            else begin p = 64'(sa % sb); r = p[31:0]; end
         end
         default: begin
            if (b == 32'h0) r = a;
            else begin p = 64'(ua % ub); r = p[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && b == 32'h0) return 1;
      if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // One complete operation: start at cycle 0, expect done at cycle lat.
   // Returns one cycle after done so a following call starts the cycle after done.
   task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int   cyc;
      logic seen;
      logic busy_ok;
      funct3 = f3;
      op1    = a;
      op2    = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      op1    = $urandom;
      op2    = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      cyc     = 1;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (cyc <= 40 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
         end
      end
      chk({name, " done seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({name, " latency"}, 32'(cyc), 32'(lat));
         chk({name, " result"}, result, exp);
         chk({name, " busy at done"}, 32'(busy), 32'd0);
         chk({name, " busy before done"}, 32'(busy_ok), 32'd1);
         tick();
         chk({name, " done one cycle"}, 32'(done), 32'd0);
         chk({name, " result held"}, result, exp);
      end
   endtask

   vec_t vecs[14];

   initial begin
      int          cyc;
      logic        bad;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      int          sel;

      rst    = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      op1    = 32'h0;
      op2    = 32'h0;

      vecs[0]  = '{"MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{"MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
      vecs[2]  = '{"MULHSU min*min",  3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34};
      vecs[3]  = '{"MULHU min*min",   3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
      vecs[4]  = '{"DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34};
      vecs[5]  = '{"REM -7%2",        3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34};
      vecs[6]  = '{"DIVU ffff/16",    3'b101, 32'hFFFF_FFFF, 32'd16,         32'h0FFF_FFFF, 34};
      vecs[7]  = '{"REMU ffff%16",    3'b111, 32'hFFFF_FFFF, 32'd16,         32'h0000_000F, 34};
      vecs[8]  = '{"DIVU 5/0",        3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
      vecs[9]  = '{"REM 5%0",         3'b110, 32'd5,          32'd0,          32'd5,         1};
      vecs[10] = '{"DIV min/-1",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{"REM min%-1",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[12] = '{"DIV 7/-2",        3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
      vecs[13] = '{"REM 7%-2",        3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};

      // reset state
      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // directed table
      for (int i = 0; i < 14; i++) begin
         do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      // flush mid-CALC: result keeps the last value (REM 7%-2 = 1)
      funct3 = 3'b000; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush busy low", 32'(busy), 32'd0);
      bad = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) bad = 1'b1;
         tick();
      end
      chk("flush no done", 32'(bad), 32'd0);
      chk("flush result kept", result, 32'd1);
      do_op("DIVU 100/7 after flush", 3'b101, 32'd100, 32'd7, 32'd14, 34);

      // flush and start together in IDLE: nothing starts
      funct3 = 3'b000; op1 = 32'd5; op2 = 32'd5; start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      chk("flush+start busy", 32'(busy), 32'd0);
      chk("flush+start done", 32'(done), 32'd0);
      tick();
      chk("flush+start idle", 32'(busy | done), 32'd0);

      // start during the done cycle is not accepted
      funct3 = 3'b000; op1 = 32'd6; op2 = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (cyc < 40 && !done) begin tick(); cyc++; end
      chk("done-cycle op result", result, 32'd42);
      start = 1'b1; op1 = 32'd2; op2 = 32'd2;
      tick();
      start = 1'b0;
      chk("start in done cycle ignored", 32'(busy), 32'd0);
      tick();
      chk("start in done cycle no done", 32'(done), 32'd0);

      // asynchronous reset mid-CALC
      funct3 = 3'b000; op1 = 32'd11; op2 = 32'd13; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      #2;
      rst = 1'b0;
      #1;
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst done", 32'(done), 32'd0);
      chk("async rst result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // back-to-back, second start in the cycle after done
      do_op("MUL 3*4 first", 3'b000, 32'd3, 32'd4, 32'd12, 34);
      do_op("MUL 3*4 second", 3'b000, 32'd3, 32'd4, 32'd12, 34);

      // randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) rb = 32'h0;
         else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (sel == 2) rb = 32'($urandom_range(1, 15));
         else if (sel == 3) ra = 32'($urandom_range(0, 255));
         do_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf3, ra, rb), rf3, ra, rb,
               ref_model(rf3, ra, rb), ref_latency(rf3, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Accepts the same operand pair and funct3 as the ALU when the decoder flags an M-extension R-type instruction (funct7 = 0000001).
- Produces a 32-bit result after a multi-cycle computation and drives busy so the hazard logic stalls IF/ID/EX while it works.
- Shift-add multiply and restoring divide share one datapath.

Parameters:
- XLEN, 32, operand/result width; equals `REG_DATA_WIDTH.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- flush  input  1  pipeline kill; aborts the operation in progress.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  input  XLEN  rs1 value (multiplicand/dividend).
- op2  input  XLEN  rs2 value (multiplier/divisor).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  XLEN  result; held stable after done until the next accepted start.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; busy = 0, done = 0, result = 0; counter and internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start = 1 and flush = 0, latch funct3.
  - Latch absolute operand values: signed for MULH/DIV/REM, op1 only for MULHSU, none for unsigned ops.
  - Latch the result-sign flags.
  - Clear the 64-bit accumulator (multiply) or the remainder (divide).
  - Counter = 0.
  - Next state is CALC, except on the special cases below, which go to DONE.
- Special cases (decided in IDLE, result written directly):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow, op1 = 0x80000000 and op2 = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC (one bit per cycle, exactly XLEN cycles, counter increments; leave for FIX when counter = XLEN-1):
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the accumulator high half; then shift the {carry, acc} right by 1.
  - Divide: restoring step. Shift {rem, quot} left by 1; if rem >= divisor then subtract and set the quotient LSB.
- FIX (one cycle):
  - Apply two's-complement negation where the sign flags require it.
  - Multiply: negate the 64-bit product if the operand signs differ (MULHSU: op1 sign only).
  - Quotient: negated if the signs of op1 and op2 differ.
  - Remainder: takes the sign of op1.
  - Select the output: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - Register result; go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
- Latency, normal path: start accepted at cycle 0, busy high cycles 1..33, done at cycle 34 (32 CALC + FIX + DONE).
- Latency, special-case path: done at cycle 1; busy never asserts.
- start while busy: ignored. The pipeline is stalled, so this is a protocol violation, but it is harmless.
- start and done in the same cycle: start is not accepted (state ≠ IDLE); the requester re-asserts start.
- flush in CALC or FIX:
  - Go to IDLE next cycle; busy = 0.
  - done is not asserted; result keeps its previous value.
- flush in DONE: done still pulses; the pipeline discards it.
- flush and start in the same IDLE cycle: flush wins; no operation starts.
- All arithmetic is unsigned on magnitude registers; XLEN+1-bit adders provide carry and borrow.

Decomposition:
- Shared defines go into riscv_def.v: funct3 encodings for the M extension (`MUL_F3 ... `REMU_F3), `FUNCT7_MULDIV, and state encodings for the unit.
- One natural sub-module, muldiv_negate: a combinational conditional two's-complement negator for 64-bit/32-bit values. It is used in IDLE (operand abs) and FIX (result sign), and is instantiated twice.

Test Plan:
- MUL: op1 = 7, op2 = -3 (0xFFFFFFFD) -> done at cycle 34, result = 0xFFFFFFEB; busy high cycles 1..33.
- MULH/MULHSU/MULHU with op1 = op2 = 0x80000000 -> 0x40000000 / 0xC0000000 / 0x40000000.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF / 16 -> 0x0FFFFFFF; REMU -> 0x0000000F.
- DIVU 5 / 0 -> 0xFFFFFFFF at cycle 1; REM 5 % 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0; busy never asserts.
- MUL started, flush at cycle 10 -> busy low at cycle 11, no done pulse, result unchanged. Then start DIVU 100 / 7 -> 14 at cycle 34.
- Assert rst low mid-CALC -> busy, done, result = 0 immediately (asynchronous). Release, then back-to-back MUL 3*4 followed by start in the cycle after done -> 12, then 12 again after 34 cycles.
